// File: rtl/stage_sequencer_pkg.sv
// Shared types for the multi-cycle stage sequencer: stage encoding and
// the width helper for the memory wait timer.
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        MEMORY    = 3'd4,
        WRITEBACK = 3'd5,
        HALT      = 3'd6,
        FAULT     = 3'd7
    } stage_t;

    // Bits needed to count from 0 up to max_wait inclusive.
    function automatic int wait_w(input int max_wait);
        return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/stage_sequencer_wait_timer.sv
// Wait counter shared by FETCH and MEMORY. It flags when the next missed
// ready would bring the wait count up to LIMIT.
module wait_timer #(
    parameter int LIMIT = 15,
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle control FSM: steps each instruction through fetch, decode,
// execute, optional memory and writeback, and owns the PC write strobe.
module stage_sequencer
    import seq_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    input  logic        imem_ready,
    output logic        dmem_req,
    input  logic        dmem_ready,
    input  logic        is_mem,
    input  logic        is_wb,
    input  logic        branch_taken,
    input  logic [31:0] target_addr,
    input  logic        halt,
    output logic [2:0]  stage,
    output logic        ir_we,
    output logic        rf_we,
    output logic        pc_write,
    output logic        pc_src,
    output logic [31:0] jump_addr,
    output logic [31:0] retired,
    output logic        halted,
    output logic        fault
);

    localparam int WAIT_W = wait_w(MAX_WAIT);

    stage_t state;
    stage_t next_state;

    logic is_mem_q;
    logic is_wb_q;
    logic taken_q;
    logic timer_clear;
    logic timer_en;
    logic timer_expired;

    wait_timer #(
        .LIMIT (MAX_WAIT),
        .WIDTH (WAIT_W)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (timer_en),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The timer sits cleared in every other state, so it always starts
    // from zero when FETCH or MEMORY is entered.
    always_comb begin
        next_state  = state;
        timer_clear = 1'b1;
        timer_en    = 1'b0;
        unique case (state)
            IDLE:      next_state = FETCH;
            FETCH: begin
                timer_clear = 1'b0;
                if (imem_ready) begin
                    next_state = DECODE;
                end else begin
                    timer_en = 1'b1;
                    if (timer_expired) next_state = FAULT;
                end
            end
            DECODE:    next_state = EXECUTE;
            EXECUTE:   next_state = is_mem_q ? MEMORY : WRITEBACK;
            MEMORY: begin
                timer_clear = 1'b0;
                if (dmem_ready) begin
                    next_state = WRITEBACK;
                end else begin
                    timer_en = 1'b1;
                    if (timer_expired) next_state = FAULT;
                end
            end
            WRITEBACK: next_state = halt ? HALT : FETCH;
            HALT:      next_state = HALT;
            FAULT:     next_state = FAULT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            is_mem_q  <= 1'b0;
            is_wb_q   <= 1'b0;
            taken_q   <= 1'b0;
            jump_addr <= '0;
            retired   <= '0;
        end else begin
            if (state == DECODE) begin
                is_mem_q <= is_mem;
                is_wb_q  <= is_wb;
            end
            if (state == EXECUTE) begin
                taken_q   <= branch_taken;
                jump_addr <= target_addr;
            end
            if (state == WRITEBACK) begin
                retired <= retired + 32'd1;
            end
        end
    end

    // Moore strobes; only ir_we looks at an input so the IR loads the
    // same cycle instruction data is valid.
    assign stage    = state;
    assign imem_req = (state == FETCH);
    assign ir_we    = (state == FETCH) && imem_ready;
    assign dmem_req = (state == MEMORY);
    assign rf_we    = (state == WRITEBACK) && is_wb_q;
    assign pc_write = (state == WRITEBACK);
    assign pc_src   = (state == WRITEBACK) && taken_q;
    assign halted   = (state == HALT);
    assign fault    = (state == FAULT);

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer: instruction-level timing model
// driven with directed and randomized instruction mixes.
module tb_stage_sequencer;

    localparam int S_IDLE  = 0;
    localparam int S_FETCH = 1;
    localparam int S_DEC   = 2;
    localparam int S_EXE   = 3;
    localparam int S_MEM   = 4;
    localparam int S_WB    = 5;
    localparam int S_HALT  = 6;
    localparam int S_FAULT = 7;
    localparam int LIMIT   = 15;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic        imem_ready;
    logic        dmem_req;
    logic        dmem_ready;
    logic        is_mem;
    logic        is_wb;
    logic        branch_taken;
    logic [31:0] target_addr;
    logic        halt;
    logic [2:0]  stage;
    logic        ir_we;
    logic        rf_we;
    logic        pc_write;
    logic        pc_src;
    logic [31:0] jump_addr;
    logic [31:0] retired;
    logic        halted;
    logic        fault;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] exp_retired;
    logic [31:0] exp_jump;
    logic        m_wb;
    logic        m_tk;

    stage_sequencer #(.MAX_WAIT(LIMIT)) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_ready   (imem_ready),
        .dmem_req     (dmem_req),
        .dmem_ready   (dmem_ready),
        .is_mem       (is_mem),
        .is_wb        (is_wb),
        .branch_taken (branch_taken),
        .target_addr  (target_addr),
        .halt         (halt),
        .stage        (stage),
        .ir_we        (ir_we),
        .rf_we        (rf_we),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .jump_addr    (jump_addr),
        .retired      (retired),
        .halted       (halted),
        .fault        (fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Expected outputs follow from the stage the model says we are in.
    task automatic check_now(input int s);
        logic [7:0] exp_strb;
        logic [7:0] act_strb;
        exp_strb = {s == S_FETCH, (s == S_FETCH) && imem_ready, s == S_MEM,
                    (s == S_WB) && m_wb, s == S_WB, (s == S_WB) && m_tk,
                    s == S_HALT, s == S_FAULT};
        act_strb = {imem_req, ir_we, dmem_req, rf_we, pc_write, pc_src, halted, fault};
        check_output("stage", {29'd0, stage}, s[31:0]);
        check_output("strobes", {24'd0, act_strb}, {24'd0, exp_strb});
        check_output("jump_addr", jump_addr, exp_jump);
        check_output("retired", retired, exp_retired);
    endtask

    task automatic check_cycle(input int s);
        @(negedge clk);
        check_now(s);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus();
        imem_ready   = 1'($urandom);
        dmem_ready   = 1'($urandom);
        is_mem       = 1'($urandom);
        is_wb        = 1'($urandom);
        branch_taken = 1'($urandom);
        target_addr  = $urandom;
        halt         = 1'($urandom);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        exp_retired = '0;
        exp_jump    = '0;
        m_wb        = 1'b0;
        m_tk        = 1'b0;
        check_now(S_IDLE);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        apply_stimulus();
        check_cycle(S_IDLE);
    endtask

    task automatic do_fetch(input int cycles, input bit arrives);
        for (int i = 0; i < cycles; i++) begin
            apply_stimulus();
            imem_ready = arrives && (i == cycles - 1);
            check_cycle(S_FETCH);
        end
    endtask

    task automatic do_decode(input bit mem, input bit wb);
        apply_stimulus();
        is_mem = mem;
        is_wb  = wb;
        halt   = 1'b1;
        check_cycle(S_DEC);
        m_wb = wb;
    endtask

    task automatic do_execute(input bit tk, input logic [31:0] tgt);
        apply_stimulus();
        branch_taken = tk;
        target_addr  = tgt;
        check_cycle(S_EXE);
        m_tk     = tk;
        exp_jump = tgt;
    endtask

    task automatic do_memory(input int cycles, input bit arrives);
        for (int i = 0; i < cycles; i++) begin
            apply_stimulus();
            dmem_ready = arrives && (i == cycles - 1);
            check_cycle(S_MEM);
        end
    endtask

    task automatic do_writeback(input bit hlt);
        apply_stimulus();
        halt = hlt;
        check_cycle(S_WB);
        exp_retired = exp_retired + 32'd1;
    endtask

    task automatic run_instr(input int fw, input int mw, input bit mem, input bit wb,
                             input bit tk, input logic [31:0] tgt, input bit hlt);
        do_fetch(fw + 1, 1'b1);
        do_decode(mem, wb);
        do_execute(tk, tgt);
        if (mem) do_memory(mw + 1, 1'b1);
        do_writeback(hlt);
    endtask

    initial begin
        reset = 1'b1;
        apply_stimulus();
        #3;
        do_reset();

        // three back-to-back ALU instructions, then a delayed load
        for (int k = 0; k < 3; k++) run_instr(0, 0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        run_instr(0, 2, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

        // taken branch followed by a fall-through instruction
        run_instr(0, 0, 1'b0, 1'b0, 1'b1, 32'h0000_0040, 1'b0);
        run_instr(1, 0, 1'b0, 1'b1, 1'b0, 32'h0000_1234, 1'b0);

        // ready arriving on the last allowed wait cycle does not fault
        run_instr(LIMIT - 1, LIMIT - 1, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);

        for (int k = 0; k < 20; k++) begin
            run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      1'($urandom), 1'($urandom), 1'($urandom), $urandom, 1'b0);
        end

        // halt in writeback freezes the core
        run_instr(0, 0, 1'b0, 1'b1, 1'b0, 32'h0000_0080, 1'b1);
        m_wb = 1'b0;
        m_tk = 1'b0;
        for (int k = 0; k < 3; k++) begin
            apply_stimulus();
            check_cycle(S_HALT);
        end

        // reset mid-MEMORY aborts without strobes
        do_reset();
        run_instr(0, 0, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 1'b0);
        do_fetch(1, 1'b1);
        do_decode(1'b1, 1'b1);
        do_execute(1'b1, 32'h0000_0200);
        do_memory(1, 1'b0);
        do_reset();

        // instruction memory never ready: fault after LIMIT fetch cycles
        do_fetch(LIMIT, 1'b0);
        m_wb = 1'b0;
        m_tk = 1'b0;
        for (int k = 0; k < 3; k++) begin
            apply_stimulus();
            check_cycle(S_FAULT);
        end

        // data memory never ready
        do_reset();
        do_fetch(1, 1'b1);
        do_decode(1'b1, 1'b1);
        do_execute(1'b0, 32'h0000_0300);
        do_memory(LIMIT, 1'b0);
        m_wb = 1'b0;
        m_tk = 1'b0;
        for (int k = 0; k < 3; k++) begin
            apply_stimulus();
            check_cycle(S_FAULT);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/stage_sequencer.md
# stage_sequencer

Multi-cycle control FSM for the RISC-V core. It steps each instruction through FETCH, DECODE, EXECUTE, optional MEMORY and WRITEBACK, and waits on ready handshakes from instruction and data memory. It drives the PC update (`pc_write`/`pc_src`/`jump_addr`), IR and register-file write enables, and counts retired instructions. It replaces the PC's free-running 5-cycle counter as the source of the PC write strobe.

## Interface
- `MAX_WAIT`, default 15: maximum cycles a memory request may wait for ready before a fault.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `imem_req` out 1: instruction fetch request.
- `imem_ready` in 1: instruction memory data valid.
- `dmem_req` out 1: data memory request (load/store).
- `dmem_ready` in 1: data memory access complete.
- `is_mem` in 1: decoded instruction is a load/store; sampled in DECODE.
- `is_wb` in 1: decoded instruction writes rd; sampled in DECODE.
- `branch_taken` in 1: EX branch/jump resolution; sampled in EXECUTE.
- `target_addr` in 32: EX branch/jump target; sampled in EXECUTE.
- `halt` in 1: stop request; sampled in WRITEBACK only.
- `stage` out 3: current state encoding (`stage_t`).
- `ir_we` out 1: instruction register load strobe.
- `rf_we` out 1: register-file write strobe.
- `pc_write` out 1: PC update strobe.
- `pc_src` out 1: 1 selects `jump_addr`, 0 selects PC+4.
- `jump_addr` out 32: registered branch target.
- `retired` out 32: retired-instruction count.
- `halted` out 1: sticky halt flag.
- `fault` out 1: sticky memory-timeout flag.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT, FAULT.
- IDLE: entered on reset. Moves to FETCH on the first clock after reset deasserts. All strobes low.
- FETCH: `imem_req`=1. When `imem_ready`=1: `ir_we`=1 that cycle, next state DECODE. Otherwise stay and increment the wait counter.
- DECODE: one cycle. Latch `is_mem`, `is_wb`.
- EXECUTE: one cycle. Latch `branch_taken` into the taken register and `target_addr` into `jump_addr`. Next state is MEMORY if the latched `is_mem` is 1, else WRITEBACK.
- MEMORY: `dmem_req`=1 until `dmem_ready`=1, then WRITEBACK.
- WRITEBACK: one cycle.
  - `rf_we` = latched `is_wb`; `pc_write`=1; `pc_src` = latched taken.
  - `retired` increments (wraps 0xFFFFFFFF→0).
  - Next state is HALT if `halt`=1, else FETCH.
- HALT: terminal until reset. `halted`=1, all strobes low.
- Timeout:
  - The wait counter clears on entry to FETCH or MEMORY.
  - If the counter reaches `MAX_WAIT` with ready still low, the next state is FAULT. `fault`=1, all strobes low, terminal until reset.
  - Ready arriving in the same cycle the count reaches `MAX_WAIT` wins: no fault.
- Strobes are Moore-decoded from state and latched flags, except `ir_we`, which is FETCH && `imem_ready`.
- Outside WRITEBACK, `pc_src` is 0.
- `jump_addr` holds its value until the next EXECUTE.

## Timing
- Reset (async assert): state=IDLE; all strobes 0; `retired`=0; `jump_addr`=0; `halted`=0; `fault`=0; latched flags=0.
- Zero-wait instruction latency: 4 cycles (F,D,E,W) for non-memory instructions, 5 cycles with MEMORY.
- Each cycle of ready delay adds one cycle.
- Exactly one `pc_write` pulse per retired instruction, coincident with the `retired` increment.
- `halt` outside WRITEBACK is ignored.
- Reset asserted mid-instruction aborts immediately. No partial `rf_we` or `pc_write` is produced.

## Structure
- Package `seq_pkg`: `stage_t` enum (3 bits; IDLE=0 … FAULT=7) and a `WAIT_W = $clog2(MAX_WAIT+1)` helper function.
- Sub-module `wait_timer`: loadable counter with clear, enable and `expired` output, shared by FETCH and MEMORY.
- `PC` is driven by `pc_write`, `pc_src` and `jump_addr`; its internal counter is bypassed.

## Test plan
- Reset, then `imem_ready` held 1, `is_mem`=0, `is_wb`=1, 3 instructions → `pc_write` pulses every 4 cycles, `retired`=3, `rf_we` high in each WRITEBACK.
- `is_mem`=1 with `dmem_ready` delayed 2 cycles → instruction takes 7 cycles; `dmem_req` high for 3 cycles.
- `branch_taken`=1, `target_addr`=0x40 in EXECUTE → in WRITEBACK `pc_src`=1, `jump_addr`=0x40; next instruction `pc_src`=0.
- `imem_ready` held 0 with `MAX_WAIT`=15 → FAULT entered after 15 FETCH cycles, `fault`=1, all strobes 0 thereafter. Repeat with ready arriving on cycle 15 → no fault.
- `halt`=1 during DECODE only → ignored. `halt`=1 in WRITEBACK → HALT, `halted`=1, `retired` frozen.
- Reset asserted mid-MEMORY → outputs cleared asynchronously; after release, one IDLE cycle, then FETCH with `retired`=0.
